// File: rtl/attention_pass_sequencer.sv
// attention_pass_sequencer: runs chained multi-pass MAC jobs and mirrors masked pass results into the scratchpad
module attention_pass_sequencer #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int MAX_PASSES = 4,
   parameter int PIDX_W     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dut_valid,
   output logic                  dut_ready,
   input  logic [PIDX_W-1:0]     cfg_num_passes,
   input  logic [MAX_PASSES-1:0] cfg_scratch_mask,
   output logic                  mac_valid,
   input  logic                  mac_ready,
   output logic [ADDR_W-1:0]     weight_base_addr,
   output logic [ADDR_W-1:0]     result_base_addr,
   input  logic [ADDR_W-1:0]     mac_weight_raddr,
   input  logic                  mac_result_we,
   input  logic [ADDR_W-1:0]     mac_result_waddr,
   input  logic [DATA_W-1:0]     mac_result_wdata,
   output logic                  sp_we,
   output logic [ADDR_W-1:0]     sp_waddr,
   output logic [DATA_W-1:0]     sp_wdata,
   output logic [PIDX_W-1:0]     pass_idx,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ADVANCE, DONE} state_t;
   localparam int MASK_W = 2**PIDX_W;
   localparam logic [PIDX_W-1:0] MAXP = PIDX_W'(MAX_PASSES);
   state_t state, state_n;
   logic [PIDX_W-1:0] np;
   logic [MASK_W-1:0] mask;
   logic [ADDR_W-1:0] sp_base, last_res, last_res_n;
   logic seen_busy, accept, complete, mirror;
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      complete  = 1'b0;
      dut_ready = state == IDLE;
      busy      = state != IDLE;
      done      = state == DONE;
      mac_valid = (state == LAUNCH) && mac_ready;
      case (state)
         IDLE:    if (dut_valid) begin accept = 1'b1; state_n = LAUNCH; end
         LAUNCH:  if (mac_ready) state_n = RUN;
         RUN:     if (seen_busy && mac_ready) begin complete = 1'b1; state_n = ADVANCE; end
         ADVANCE: state_n = (pass_idx + PIDX_W'(1) == np) ? DONE : LAUNCH;
         default: state_n = IDLE;
      endcase
   end
   // a write landing in the completion cycle still counts toward the pass extent
   assign last_res_n = mac_result_we ? mac_result_waddr : last_res;
   assign mirror     = (state == RUN) && mask[pass_idx] && mac_result_we;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         np               <= '0;
         mask             <= '0;
         weight_base_addr <= ADDR_W'(1);
         result_base_addr <= '0;
         pass_idx         <= '0;
         sp_base          <= '0;
         last_res         <= '0;
         seen_busy        <= 1'b0;
         sp_we            <= 1'b0;
         sp_waddr         <= '0;
         sp_wdata         <= '0;
      end else begin
         sp_we <= mirror;
         if (mirror) begin
            sp_waddr <= mac_result_waddr - result_base_addr + sp_base;
            sp_wdata <= mac_result_wdata;
         end
         if (accept) begin
            np <= (cfg_num_passes == '0) ? PIDX_W'(1) : (cfg_num_passes > MAXP) ? MAXP : cfg_num_passes;
            mask             <= MASK_W'(cfg_scratch_mask);
            weight_base_addr <= ADDR_W'(1);
            result_base_addr <= '0;
            pass_idx         <= '0;
            sp_base          <= '0;
         end
         if (state == LAUNCH && mac_ready) begin
            seen_busy <= 1'b0;
            last_res  <= result_base_addr - ADDR_W'(1);
         end
         if (state == RUN) begin
            if (!mac_ready) seen_busy <= 1'b1;
            last_res <= last_res_n;
         end
         if (complete) begin
            weight_base_addr <= mac_weight_raddr + ADDR_W'(1);
            result_base_addr <= last_res_n + ADDR_W'(1);
            if (mask[pass_idx]) sp_base <= sp_base + last_res_n - result_base_addr + ADDR_W'(1);
         end
         if (state == ADVANCE) pass_idx <= pass_idx + PIDX_W'(1);
      end
   end
endmodule

// File: tb/tb_attention_pass_sequencer.sv
// tb_attention_pass_sequencer: stub MAC plus mirror scoreboard for the multi-pass sequencer
module tb_attention_pass_sequencer;
   logic clk = 0, reset = 0, dut_valid = 0;
   logic [2:0] cfg_num_passes = 0;
   logic [3:0] cfg_scratch_mask = 0;
   logic mac_ready = 1, mac_result_we = 0;
   logic [11:0] mac_weight_raddr = 0, mac_result_waddr = 0;
   logic [31:0] mac_result_wdata = 0;
   logic dut_ready, mac_valid, sp_we, busy, done;
   logic [11:0] weight_base_addr, result_base_addr, sp_waddr;
   logic [31:0] sp_wdata;
   logic [2:0] pass_idx;

   attention_pass_sequencer #(.ADDR_W(12), .DATA_W(32), .MAX_PASSES(4), .PIDX_W(3)) dut (
      .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(dut_ready),
      .cfg_num_passes(cfg_num_passes), .cfg_scratch_mask(cfg_scratch_mask),
      .mac_valid(mac_valid), .mac_ready(mac_ready),
      .weight_base_addr(weight_base_addr), .result_base_addr(result_base_addr),
      .mac_weight_raddr(mac_weight_raddr), .mac_result_we(mac_result_we),
      .mac_result_waddr(mac_result_waddr), .mac_result_wdata(mac_result_wdata),
      .sp_we(sp_we), .sp_waddr(sp_waddr), .sp_wdata(sp_wdata),
      .pass_idx(pass_idx), .busy(busy), .done(done));

   always #5 clk = ~clk;

   typedef struct {int c; logic [11:0] a; logic [31:0] d;} exp_t;
   exp_t sb[$];
   exp_t e;
   int errors = 0, checks = 0, cyc = 0;
   int nw = 4, stall_p0 = 0;
   bit linger = 0, last_at_done = 0, wrap_p0 = 0;
   int m_pass = 0, nvalid = 0, ndone = 0, bad_valid = 0;
   bit prev_mv = 0;
   logic [11:0] m_rb = 0, m_wb = 1, m_sp = 0;
   logic [3:0] m_mask = 0;
   logic [63:0] outs;
   localparam logic [63:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'd1, 12'd0, 32'd0};

   assign outs = {dut_ready, busy, mac_valid, done, sp_we, pass_idx, weight_base_addr, result_base_addr, sp_wdata};

   always @(posedge clk) cyc <= cyc + 1;

   // stub MAC: one busy cycle minimum, nw sequential result writes from the pass's result base
   initial begin : mac_stub
      int p;
      bit aborted;
      exp_t x;
      forever begin
         @(negedge clk);
         if (mac_valid && !reset) begin
            p = m_pass;
            m_pass++;
            checks += 3;
            if (pass_idx !== 3'(p)) begin errors++; $display("FAIL pass_idx: got %0d want %0d", pass_idx, p); end
            if (weight_base_addr !== m_wb) begin errors++; $display("FAIL weight_base pass %0d: got %0d want %0d", p, weight_base_addr, m_wb); end
            if (result_base_addr !== m_rb) begin errors++; $display("FAIL result_base pass %0d: got %0d want %0d", p, result_base_addr, m_rb); end
            aborted = 0;
            @(posedge clk); #1;
            mac_ready = linger;
            if (linger) begin @(posedge clk); #1; mac_ready = 0; end
            for (int k = 0; k < nw; k++) begin
               if (reset) begin aborted = 1; break; end
               mac_result_we = 1;
               mac_result_waddr = m_rb + 12'(k);
               mac_result_wdata = $urandom;
               mac_weight_raddr = m_wb + 12'(k);
               if (last_at_done && k == nw - 1) mac_ready = 1;
               if (m_mask[p]) begin
                  x.c = cyc + 1; x.a = m_sp; x.d = mac_result_wdata;
                  sb.push_back(x);
                  m_sp++;
               end
               @(posedge clk); #1;
            end
            if (nw == 0 && !aborted) begin @(posedge clk); #1; end
            mac_result_we = 0;
            mac_ready = 1;
            if (!aborted && !reset) begin
               if (wrap_p0 && p == 0) mac_weight_raddr = 12'hFFF;
               else if (nw == 0) mac_weight_raddr = m_wb - 12'd1;
               m_rb = m_rb + 12'(nw);
               m_wb = mac_weight_raddr + 12'd1;
               if (stall_p0 > 0 && p == 0) begin
                  @(posedge clk); #1;
                  mac_ready = 0;
                  repeat (stall_p0) begin @(posedge clk); #1; end
                  mac_ready = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mac_valid) begin
         nvalid++;
         if (prev_mv || !mac_ready) bad_valid++;
      end
      prev_mv = mac_valid;
      if (done) ndone++;
      if (sp_we) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sp_unexpected: got sp_we=1 addr %0d, want no write", sp_waddr);
         end else begin
            e = sb.pop_front();
            if (sp_waddr !== e.a || sp_wdata !== e.d || cyc !== e.c) begin
               errors++;
               $display("FAIL sp_mirror: got addr %0d data %h cyc %0d, want addr %0d data %h cyc %0d", sp_waddr, sp_wdata, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   task automatic start_job(input int npc, input logic [3:0] mask);
      m_pass = 0; m_rb = 0; m_wb = 1; m_sp = 0; m_mask = mask;
      cfg_num_passes = 3'(npc);
      cfg_scratch_mask = mask;
      dut_valid = 1;
      @(negedge clk);
      dut_valid = 0;
      cfg_num_passes = ~cfg_num_passes;
      cfg_scratch_mask = ~cfg_scratch_mask;
   endtask

   task automatic run_job(input int npc, input logic [3:0] mask, input int exp_p, input bit pulse);
      int t, n0, d0;
      @(negedge clk);
      checks++;
      if (dut_ready !== 1'b1) begin errors++; $display("FAIL ready_before_job: got %b want 1", dut_ready); end
      n0 = nvalid; d0 = ndone;
      start_job(npc, mask);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b want 1", busy); end
      t = 0;
      while (t < 3000) begin
         if (done) break;
         if (pulse) dut_valid = (t == 8);
         @(negedge clk);
         t++;
      end
      dut_valid = 0;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL done_timeout: got done=%b want 1 within 3000 cycles", done); end
      checks++;
      if (result_base_addr !== m_rb) begin errors++; $display("FAIL final_result_base: got %0d want %0d", result_base_addr, m_rb); end
      @(negedge clk);
      checks += 6;
      if ({dut_ready, busy} !== 2'b10) begin errors++; $display("FAIL idle_after_done: got ready/busy %b want 10", {dut_ready, busy}); end
      if (nvalid - n0 !== exp_p) begin errors++; $display("FAIL mac_valid_count: got %0d want %0d", nvalid - n0, exp_p); end
      if (ndone - d0 !== 1) begin errors++; $display("FAIL done_count: got %0d want 1", ndone - d0); end
      if (sb.size() !== 0) begin errors++; $display("FAIL sp_missing: got %0d unmirrored writes want 0", sb.size()); end
      if (bad_valid !== 0) begin errors++; $display("FAIL mac_valid_shape: got %0d bad pulses want 0", bad_valid); end
      if (m_pass !== exp_p) begin errors++; $display("FAIL pass_count: got %0d want %0d", m_pass, exp_p); end
   endtask

   task automatic test_reset;
      #1 reset = 1;
      @(negedge clk);
      checks++;
      if (outs !== RST_VEC || sp_waddr !== 12'd0) begin errors++; $display("FAIL reset_values: got %h/%0d want %h/0", outs, sp_waddr, RST_VEC); end
      reset = 0;
      @(negedge clk);
      checks++;
      if (outs !== RST_VEC) begin errors++; $display("FAIL post_reset_idle: got %h want %h", outs, RST_VEC); end
   endtask

   task automatic test_mask_single;
      nw = 4;
      run_job(3, 4'b0010, 3, 0);
   endtask

   task automatic test_mask_split;
      nw = 4;
      run_job(3, 4'b0101, 3, 0);
   endtask

   task automatic test_pass_clamp;
      nw = 2;
      run_job(0, 4'b0001, 1, 0);
      run_job(7, 4'b1111, 4, 0);
   endtask

   task automatic test_stall_linger;
      nw = 3; stall_p0 = 5; linger = 1;
      run_job(2, 4'b0011, 2, 0);
      stall_p0 = 0; linger = 0;
   endtask

   task automatic test_zero_writes;
      nw = 0;
      run_job(2, 4'b0011, 2, 0);
   endtask

   task automatic test_write_at_done;
      nw = 3; last_at_done = 1;
      run_job(2, 4'b0011, 2, 0);
      last_at_done = 0;
   endtask

   task automatic test_back_to_back_ignore;
      nw = 4;
      run_job(3, 4'b0001, 3, 1);
   endtask

   task automatic test_weight_wrap;
      nw = 2; wrap_p0 = 1;
      run_job(2, 4'b0010, 2, 0);
      wrap_p0 = 0;
   endtask

   task automatic test_reset_mid_run;
      int t;
      nw = 4;
      @(negedge clk);
      start_job(3, 4'b0010);
      t = 0;
      while (m_sp < 2 && t < 500) begin @(negedge clk); t++; end
      checks++;
      if (m_sp < 2) begin errors++; $display("FAIL reset_wait_timeout: got %0d mirrored want 2", m_sp); end
      #2 reset = 1;
      #1;
      checks++;
      if (outs !== RST_VEC || sp_waddr !== 12'd0) begin errors++; $display("FAIL reset_mid_run: got %h/%0d want %h/0", outs, sp_waddr, RST_VEC); end
      repeat (2) @(negedge clk);
      sb.delete();
      reset = 0;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, pass_idx} !== 4'd0) begin errors++; $display("FAIL idle_after_reset: got %b want 0000", {busy, pass_idx}); end
      run_job(1, 4'b0001, 1, 0);
   endtask

   initial begin
      test_reset;
      test_mask_single;
      test_mask_split;
      test_pass_clamp;
      test_stall_linger;
      test_zero_writes;
      test_write_at_done;
      test_back_to_back_ignore;
      test_weight_wrap;
      test_reset_mid_run;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/attention_pass_sequencer.md
Name: attention_pass_sequencer

Overview:
Parametrised successor to the fixed Q/K/V top-level sequencer. It runs a runtime-configurable number of back-to-back matrix-multiply passes on the shared MAC engine over a valid/ready handshake. Between passes it chains the weight-read and result-write base addresses. It mirrors the result writes of any pass selected by a per-pass mask into the scratchpad, packing all mirrored passes contiguously from scratchpad address 0.

Parameters:
ADDR_W, 12, SRAM address width
DATA_W, 32, SRAM data width
MAX_PASSES, 4, maximum passes per job (2..8)
PIDX_W, 3, pass index width, must satisfy 2^PIDX_W > MAX_PASSES

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
dut_valid  in  1  job request
dut_ready  out  1  high only in IDLE
cfg_num_passes  in  PIDX_W  passes for this job, sampled at job accept
cfg_scratch_mask  in  MAX_PASSES  bit i high: mirror pass i to scratchpad, sampled at job accept
mac_valid  out  1  one-cycle MAC start pulse
mac_ready  in  1  MAC idle/done
weight_base_addr  out  ADDR_W  MAC weight-read base for current pass
result_base_addr  out  ADDR_W  MAC result-write start for current pass
mac_weight_raddr  in  ADDR_W  MAC weight read address (snooped)
mac_result_we  in  1  MAC result write enable (snooped)
mac_result_waddr  in  ADDR_W  MAC result write address (snooped)
mac_result_wdata  in  DATA_W  MAC result write data (snooped)
sp_we  out  1  scratchpad write enable
sp_waddr  out  ADDR_W  scratchpad write address
sp_wdata  out  DATA_W  scratchpad write data
pass_idx  out  PIDX_W  current pass number
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset values: state=IDLE, dut_ready=1, mac_valid=0, weight_base_addr=1, result_base_addr=0, pass_idx=0, sp_we=0, sp_waddr=0, sp_wdata=0, busy=0, done=0. The internal sp_base register resets to 0.
- Reset asserted in any state returns the block to IDLE immediately. The in-flight job is dropped and no sp_we is emitted after reset.
- States: IDLE, LAUNCH, RUN, ADVANCE, DONE.
- IDLE: a job is accepted when dut_valid && dut_ready.
  - On accept, latch cfg_num_passes into np. If the value is 0, np=1. If it exceeds MAX_PASSES, np=MAX_PASSES.
  - On accept, latch cfg_scratch_mask, load weight_base=1, result_base=0, pass_idx=0, sp_base=0, then go to LAUNCH.
- dut_valid is ignored in all states other than IDLE.
- LAUNCH: stall while mac_ready=0. When mac_ready=1, assert mac_valid for exactly one cycle, clear the seen_busy flag, load last_res=result_base-1 (mod 2^ADDR_W), then go to RUN.
- RUN:
  - Set seen_busy when mac_ready=0.
  - On each mac_result_we, set last_res=mac_result_waddr.
  - The pass completes on the first cycle with seen_busy=1 and mac_ready=1. A mac_ready still high in the cycle right after mac_valid is not completion.
  - On completion, weight_base <= mac_weight_raddr+1, result_base <= last_res+1, then go to ADVANCE.
  - If the mask bit for the current pass is set, also sp_base <= sp_base + (last_res - old result_base + 1).
- ADVANCE: pass_idx increments. If the new pass_idx equals np, go to DONE; otherwise go to LAUNCH.
- DONE: done=1 for one cycle, then go to IDLE.
- Base addresses are not reset between jobs until the next accept.
- Mirroring: in RUN with cfg_scratch_mask[pass_idx]=1, each cycle where mac_result_we=1 produces, one cycle later:
  - sp_we=1
  - sp_waddr = mac_result_waddr - result_base_addr + sp_base
  - sp_wdata = mac_result_wdata
- If mac_result_we and completion fall in the same cycle, that write is both mirrored and counted in last_res.
- In all other cycles sp_we=0, and sp_waddr/sp_wdata hold their last values.
- All address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- A pass with zero result writes leaves result_base unchanged and adds 0 to sp_base.

Test Plan:
- np=3, mask=3'b010; stub MAC writes 4 results per pass -> result_base 0→4→8→12. Pass 1 writes to addresses 4..7 mirror to sp_waddr 0..3 with matching data, each one cycle later. done pulses once, then dut_ready=1.
- np=3, mask=3'b101, 4 writes per pass -> pass 0 mirrors to sp 0..3, pass 2 (result addresses 8..11) mirrors to sp 4..7. No sp_we during pass 1.
- cfg_num_passes=0 -> exactly one mac_valid pulse, then done. cfg_num_passes=7 with MAX_PASSES=4 -> exactly 4 mac_valid pulses.
- Hold mac_ready=0 for 5 cycles in LAUNCH -> no mac_valid until mac_ready rises, then a single-cycle pulse. mac_ready held high for 1 cycle after mac_valid -> no false completion.
- Assert reset mid-RUN of pass 1 -> outputs return to reset values in the same cycle, with no further sp_we. A new job afterwards starts from weight_base=1, result_base=0.
- Pulse dut_valid while busy -> ignored, pass count unchanged. A weight read address of 4095 at completion -> next weight_base=0 (wrap).
